// File: rtl/softmax_pkg.sv
// Shared constants and types for the tree-softmax exponent stage.
package softmax_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_FRAC_W = 10;

  typedef logic [DEF_DATA_W-1:0] fx_t;

  localparam int unsigned MODE_BASE_E = 0;
  localparam int unsigned MODE_CORR   = 1;

  // x*log2(e) ~ x + x/2 - x/16
  localparam int unsigned LOG2E_SH_A = 1;
  localparam int unsigned LOG2E_SH_B = 4;

  // quadratic mantissa correction: m -= p/4 + p/16
  localparam int unsigned CORR_SH_A = 2;
  localparam int unsigned CORR_SH_B = 4;

  localparam fx_t SAT_VAL = fx_t'(16'h7FFF);

endpackage

// File: rtl/pow2_lane.sv
// One lane of the exponent pipeline: scale, integer/fraction split, shift with saturation.
module pow2_lane
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              base_e,
  input  logic              corr,
  input  logic [DATA_W-1:0] x,
  output logic [DATA_W-1:0] pow_x,
  output logic              sat
);

  localparam int unsigned YW = DATA_W + 2;
  localparam int unsigned NW = YW - FRAC_W;
  localparam int unsigned MW = FRAC_W + 1;
  localparam int unsigned PW = 2 * FRAC_W + 1;
  localparam int unsigned WW = MW + DATA_W;
  localparam logic [MW-1:0]     ONE     = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  logic signed [YW-1:0] x_ext;
  logic signed [YW-1:0] y_c;
  logic signed [YW-1:0] y_q;

  logic [NW-1:0]     n_c;
  logic [FRAC_W-1:0] f_c;
  logic [PW-1:0]     prod_c;
  logic [MW-1:0]     p_c;
  logic [MW-1:0]     m_c;
  logic [NW-1:0]     n_q;
  logic [MW-1:0]     m_q;

  logic [WW-1:0]     wide_c;
  logic [NW-1:0]     k_c;
  logic [DATA_W-1:0] r_c;
  logic              sat_c;

  // S1: optional change of base
  assign x_ext = YW'(signed'(x));
  assign y_c   = base_e ? (x_ext + (x_ext >>> LOG2E_SH_A) - (x_ext >>> LOG2E_SH_B)) : x_ext;

  // S2: floor/fraction split and mantissa build
  assign n_c    = NW'(y_q >>> FRAC_W);
  assign f_c    = y_q[FRAC_W-1:0];
  assign prod_c = PW'(f_c) * PW'(ONE - MW'(f_c));
  assign p_c    = MW'(prod_c >> FRAC_W);

  always_comb begin
    m_c = ONE + MW'(f_c);
    if (corr) begin
      m_c = m_c - (p_c >> CORR_SH_A) - (p_c >> CORR_SH_B);
    end
  end

  // S3: scale mantissa by 2^n, saturate high, flush low
  always_comb begin
    wide_c = '0;
    k_c    = '0;
    r_c    = '0;
    sat_c  = 1'b0;
    if (!n_q[NW-1]) begin
      if (n_q >= NW'(DATA_W)) begin
        r_c   = SAT_MAX;
        sat_c = 1'b1;
      end else begin
        wide_c = WW'(m_q) << n_q;
        if (wide_c > WW'(SAT_MAX)) begin
          r_c   = SAT_MAX;
          sat_c = 1'b1;
        end else begin
          r_c = DATA_W'(wide_c);
        end
      end
    end else begin
      k_c = -n_q;
      if (k_c <= NW'(FRAC_W + 1)) begin
        r_c = DATA_W'(m_q >> k_c);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      n_q   <= '0;
      m_q   <= '0;
      pow_x <= '0;
      sat   <= 1'b0;
    end else if (en) begin
      y_q   <= y_c;
      n_q   <= n_c;
      m_q   <= m_c;
      pow_x <= r_c;
      sat   <= sat_c;
    end
  end

endmodule

// File: rtl/stage3_pow2_approx_vec.sv
// Multi-lane pipelined 2^x / e^x unit; owns the valid/mode chain and the input bypass line.
module stage3_pow2_approx_vec
  import softmax_pkg::*;
#(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic                    i_valid,
  input  logic [1:0]              i_mode,
  input  logic [LANES*DATA_W-1:0] i_x,
  output logic                    o_valid,
  output logic [LANES*DATA_W-1:0] o_pow_x,
  output logic [LANES-1:0]        o_sat,
  output logic [LANES*DATA_W-1:0] o_x_bypass
);

  localparam int unsigned VW = LANES * DATA_W;

  logic          valid_s1;
  logic          valid_s2;
  logic          corr_s1;
  logic [VW-1:0] x_s1;
  logic [VW-1:0] x_s2;

  // base_e is consumed in S1, so only the correction bit needs to travel
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_s1   <= 1'b0;
      valid_s2   <= 1'b0;
      o_valid    <= 1'b0;
      corr_s1    <= 1'b0;
      x_s1       <= '0;
      x_s2       <= '0;
      o_x_bypass <= '0;
    end else if (i_en) begin
      valid_s1   <= i_valid;
      valid_s2   <= valid_s1;
      o_valid    <= valid_s2;
      corr_s1    <= i_mode[MODE_CORR];
      x_s1       <= i_x;
      x_s2       <= x_s1;
      o_x_bypass <= x_s2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pow2_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (i_en),
      .base_e (i_mode[MODE_BASE_E]),
      .corr   (corr_s1),
      .x      (i_x[k*DATA_W +: DATA_W]),
      .pow_x  (o_pow_x[k*DATA_W +: DATA_W]),
      .sat    (o_sat[k])
    );
  end

endmodule

// File: tb/tb_stage3_pow2_approx_vec.sv
// Directed bench for stage3_pow2_approx_vec with hand-computed expected results.
module tb_stage3_pow2_approx_vec;

  localparam int unsigned LANES  = 4;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned VW     = LANES * DATA_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          valid;
  logic [1:0]    mode;
  logic [VW-1:0] x;
  logic          o_valid;
  logic [VW-1:0] o_pow_x;
  logic [3:0]    o_sat;
  logic [VW-1:0] o_x_bypass;

  int n_checks = 0;
  int n_fail   = 0;

  logic          dl_v[3];
  logic [VW-1:0] dl_p[3];
  logic [VW-1:0] dl_x[3];
  logic [3:0]    dl_s[3];
  string         dl_t[3];

  always #5 clk = ~clk;

  stage3_pow2_approx_vec #(.LANES(LANES), .DATA_W(DATA_W), .FRAC_W(10)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_valid    (valid),
    .i_mode     (mode),
    .i_x        (x),
    .o_valid    (o_valid),
    .o_pow_x    (o_pow_x),
    .o_sat      (o_sat),
    .o_x_bypass (o_x_bypass)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [15:0] w);
    return {4{w}};
  endfunction

  task automatic clear_dl();
    for (int i = 0; i < 3; i++) begin
      dl_v[i] = 1'b0;
      dl_p[i] = '0;
      dl_x[i] = '0;
      dl_s[i] = '0;
      dl_t[i] = "none";
    end
  endtask

  // Drive one cycle; the expected-value delay line advances only on enabled edges
  task automatic apply(input string tag, input logic e, input logic v, input logic [1:0] md,
                       input logic [VW-1:0] xv, input logic [VW-1:0] pv, input logic [3:0] sv);
    en = e; valid = v; mode = md; x = xv;
    @(posedge clk);
    if (e) begin
      for (int i = 2; i > 0; i--) begin
        dl_v[i] = dl_v[i-1]; dl_p[i] = dl_p[i-1]; dl_x[i] = dl_x[i-1];
        dl_s[i] = dl_s[i-1]; dl_t[i] = dl_t[i-1];
      end
      dl_v[0] = v; dl_p[0] = pv; dl_x[0] = xv; dl_s[0] = sv; dl_t[0] = tag;
    end
    #1;
    chk({dl_t[2], ".valid"}, 64'(o_valid), 64'(dl_v[2]));
    if (dl_v[2]) begin
      chk({dl_t[2], ".pow"}, o_pow_x, dl_p[2]);
      chk({dl_t[2], ".sat"}, 64'(o_sat), 64'(dl_s[2]));
      chk({dl_t[2], ".byp"}, o_x_bypass, dl_x[2]);
    end
  endtask

  task automatic vec(input string tag, input logic [1:0] md, input logic [15:0] xw,
                     input logic [15:0] pw, input logic s);
    apply(tag, 1'b1, 1'b1, md, rep(xw), rep(pw), s ? 4'hF : 4'h0);
  endtask

  task automatic bubbles(input int n);
    for (int i = 0; i < n; i++) apply("bub", 1'b1, 1'b0, 2'b00, '0, '0, 4'h0);
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) apply("stall", 1'b0, 1'b1, 2'b00, rep(16'h1400), '0, 4'h0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 64'(o_valid), 64'd0);
    chk({tag, ".pow"}, o_pow_x, 64'd0);
    chk({tag, ".sat"}, 64'(o_sat), 64'd0);
    chk({tag, ".byp"}, o_x_bypass, 64'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; mode = 2'b00; x = '0;
    clear_dl();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // lone vector followed by bubbles: latency is exactly three enabled edges
    vec("lin0", 2'b00, 16'h0000, 16'h0400, 1'b0);
    bubbles(3);
    vec("lin1",  2'b00, 16'h0400, 16'h0800, 1'b0);
    vec("lin2p5", 2'b00, 16'h0A00, 16'h1800, 1'b0);
    vec("linm05", 2'b00, 16'hFE00, 16'h0300, 1'b0);

    vec("cor2p5", 2'b10, 16'h0A00, 16'h16C0, 1'b0);
    vec("corm05", 2'b10, 16'hFE00, 16'h02D8, 1'b0);
    vec("cor0",   2'b10, 16'h0000, 16'h0400, 1'b0);

    // base-e with alternating correction on back-to-back vectors
    vec("e_lin_a", 2'b01, 16'h0400, 16'h0B80, 1'b0);
    vec("e_cor_a", 2'b11, 16'h0400, 16'h0AE4, 1'b0);
    vec("e_lin_b", 2'b01, 16'h0400, 16'h0B80, 1'b0);
    vec("e_cor_b", 2'b11, 16'h0400, 16'h0AE4, 1'b0);

    vec("sat",    2'b00, 16'h1400, 16'h7FFF, 1'b1);
    vec("flush",  2'b00, 16'h8000, 16'h0000, 1'b0);
    vec("e_flush", 2'b01, 16'h8000, 16'h0000, 1'b0);
    vec("half",   2'b00, 16'hFC00, 16'h0200, 1'b0);
    apply("mixed", 1'b1, 1'b1, 2'b00,
          {16'h0A00, 16'hFC00, 16'h8000, 16'h1400},
          {16'h1800, 16'h0200, 16'h0000, 16'h7FFF}, 4'b0001);
    bubbles(3);

    // stall mid-stream with valid held high and junk on the inputs
    vec("st0", 2'b00, 16'h0000, 16'h0400, 1'b0);
    vec("st1", 2'b00, 16'h0400, 16'h0800, 1'b0);
    stall(2);
    vec("st2", 2'b00, 16'h0A00, 16'h1800, 1'b0);
    vec("st3", 2'b00, 16'hFE00, 16'h0300, 1'b0);
    vec("st4", 2'b10, 16'h0A00, 16'h16C0, 1'b0);
    stall(2);
    bubbles(3);

    // asynchronous reset with one vector at the output and two in flight
    vec("rs0", 2'b00, 16'h0400, 16'h0800, 1'b0);
    vec("rs1", 2'b00, 16'h0A00, 16'h1800, 1'b0);
    vec("rs2", 2'b00, 16'hFE00, 16'h0300, 1'b0);
    vec("rs3", 2'b00, 16'h0000, 16'h0400, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    clear_dl();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bubbles(4);
    vec("post", 2'b01, 16'h0400, 16'h0B80, 1'b0);
    bubbles(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
